// File: rtl/comparator_pkg.sv
// Shared types and helpers for the streaming magnitude comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        CMP_LT = 2'd0,
        CMP_EQ = 2'd1,
        CMP_GT = 2'd2
    } cmp_result_t;

    // Widest statistics counter the saturating helper supports.
    localparam int unsigned MAX_CNT_W = 64;

    // Increment v, holding at the all-ones value of a w-bit counter
    // (w <= MAX_CNT_W). Callers zero-extend in and truncate out.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] v,
        input int unsigned          w
    );
        logic [MAX_CNT_W-1:0] lim;
        lim = {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - w);
        return (v == lim) ? v : v + MAX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/comparator_stream_cmp_core.sv
// Combinational signed/unsigned magnitude compare of two operands.
module cmp_core
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output cmp_result_t      res
);

    logic a_lt;

    // Resolve equality first, then order under the requested interpretation.
    always_comb begin
        a_lt = 1'b0;
        res  = CMP_EQ;
        if (a != b) begin
            if (signed_mode) a_lt = $signed(a) < $signed(b);
            else             a_lt = a < b;
            res = a_lt ? CMP_LT : CMP_GT;
        end
    end

endmodule

// File: rtl/comparator_stream.sv
// Registered streaming comparator with running GT/LT/EQ counts and max/min.
module comparator_stream
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] lt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] min_val,
    output logic             stats_valid
);

    logic             out_valid_q, out_valid_d;
    logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
    logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
    logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic [WIDTH-1:0] max_q, max_d, min_q, min_d;
    logic             sv_q, sv_d;

    logic             accept;
    cmp_result_t      pair_res, max_res, min_res;
    logic [WIDTH-1:0] pair_max, pair_min;

    // Single output register without skid: accept whenever it drains this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    cmp_core #(.WIDTH(WIDTH)) u_pair (
        .a(a), .b(b), .signed_mode(signed_mode), .res(pair_res)
    );

    // On equality either operand serves as both the pair max and min.
    assign pair_max = (pair_res == CMP_GT) ? a : b;
    assign pair_min = (pair_res == CMP_LT) ? a : b;

    // Running extrema are compared in the incoming pair's own mode.
    cmp_core #(.WIDTH(WIDTH)) u_max (
        .a(pair_max), .b(max_q), .signed_mode(signed_mode), .res(max_res)
    );
    cmp_core #(.WIDTH(WIDTH)) u_min (
        .a(pair_min), .b(min_q), .signed_mode(signed_mode), .res(min_res)
    );

    // Next-state: handshake/result register, then stats with clear taking
    // effect before any same-cycle accept.
    always_comb begin
        out_valid_d = out_valid_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        gt_cnt_d    = clear ? '0 : gt_cnt_q;
        lt_cnt_d    = clear ? '0 : lt_cnt_q;
        eq_cnt_d    = clear ? '0 : eq_cnt_q;
        max_d       = clear ? '0 : max_q;
        min_d       = clear ? '0 : min_q;
        sv_d        = clear ? 1'b0 : sv_q;

        if (accept) begin
            out_valid_d = 1'b1;
            gt_d        = (pair_res == CMP_GT);
            lt_d        = (pair_res == CMP_LT);
            eq_d        = (pair_res == CMP_EQ);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            unique case (pair_res)
                CMP_GT:  gt_cnt_d = CNT_W'(sat_inc(MAX_CNT_W'(gt_cnt_d), CNT_W));
                CMP_LT:  lt_cnt_d = CNT_W'(sat_inc(MAX_CNT_W'(lt_cnt_d), CNT_W));
                default: eq_cnt_d = CNT_W'(sat_inc(MAX_CNT_W'(eq_cnt_d), CNT_W));
            endcase
            // First pair since reset/clear loads directly; sv_d already
            // reflects a same-cycle clear.
            if (!sv_d) begin
                max_d = pair_max;
                min_d = pair_min;
            end else begin
                if (max_res == CMP_GT) max_d = pair_max;
                if (min_res == CMP_LT) min_d = pair_min;
            end
            sv_d = 1'b1;
        end
    end

    // State registers; reset drops any pending result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_cnt_q    <= '0;
            lt_cnt_q    <= '0;
            eq_cnt_q    <= '0;
            max_q       <= '0;
            min_q       <= '0;
            sv_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            gt_cnt_q    <= gt_cnt_d;
            lt_cnt_q    <= lt_cnt_d;
            eq_cnt_q    <= eq_cnt_d;
            max_q       <= max_d;
            min_q       <= min_d;
            sv_q        <= sv_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign a_gt_b      = gt_q;
    assign a_lt_b      = lt_q;
    assign a_eq_b      = eq_q;
    assign gt_count    = gt_cnt_q;
    assign lt_count    = lt_cnt_q;
    assign eq_count    = eq_cnt_q;
    assign max_val     = max_q;
    assign min_val     = min_q;
    assign stats_valid = sv_q;

endmodule

// File: tb/tb_comparator_stream.sv
// Directed bench for comparator_stream; a second CNT_W=2 instance
// shares the stimulus to exercise counter saturation.
module tb_comparator_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, out_ready, signed_mode, clear;
    logic [7:0] a, b;

    logic        in_ready, out_valid, a_gt_b, a_lt_b, a_eq_b, stats_valid;
    logic [15:0] gt_count, lt_count, eq_count;
    logic [7:0]  max_val, min_val;

    logic       s_in_ready, s_out_valid, s_gt, s_lt, s_eq, s_sv;
    logic [1:0] s_gt_cnt, s_lt_cnt, s_eq_cnt;
    logic [7:0] s_max, s_min;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    comparator_stream #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b),
        .gt_count(gt_count), .lt_count(lt_count), .eq_count(eq_count),
        .max_val(max_val), .min_val(min_val), .stats_valid(stats_valid)
    );

    comparator_stream #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .clear(clear),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .a_gt_b(s_gt), .a_lt_b(s_lt), .a_eq_b(s_eq),
        .gt_count(s_gt_cnt), .lt_count(s_lt_cnt), .eq_count(s_eq_cnt),
        .max_val(s_max), .min_val(s_min), .stats_valid(s_sv)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; samples taken 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv,
                         input logic sm);
        in_valid    = v;
        a           = av;
        b           = bv;
        signed_mode = sm;
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        #12;
        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", {a_gt_b, a_lt_b, a_eq_b}, 0);
        chk("rst_counts", {gt_count, lt_count, eq_count}, 0);
        chk("rst_maxmin", {max_val, min_val}, 0);
        chk("rst_stats_valid", stats_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // unsigned 5 < 9
        drive(1'b1, 8'h05, 8'h09, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_flags", {a_gt_b, a_lt_b, a_eq_b}, 3'b010);
        chk("t1_lt_count", lt_count, 1);
        chk("t1_max", max_val, 8'h09);
        chk("t1_min", min_val, 8'h05);
        chk("t1_stats_valid", stats_valid, 1);
        tick();
        chk("t1_drain", out_valid, 0);
        chk("t1_flag_hold", {a_gt_b, a_lt_b, a_eq_b}, 3'b010);

        // clear alone
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_counts", {gt_count, lt_count, eq_count}, 0);
        chk("clr_stats", {max_val, min_val, 7'd0, stats_valid}, 0);
        chk("clr_flags_kept", {a_gt_b, a_lt_b, a_eq_b}, 3'b010);

        // 0x80 vs 0x7F unsigned then signed, back-to-back
        drive(1'b1, 8'h80, 8'h7F, 1'b0);
        tick();
        chk("t2_unsigned", {a_gt_b, a_lt_b, a_eq_b}, 3'b100);
        chk("t2_u_max", max_val, 8'h80);
        chk("t2_u_min", min_val, 8'h7F);
        drive(1'b1, 8'h80, 8'h7F, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("t2_signed", {a_gt_b, a_lt_b, a_eq_b}, 3'b010);
        chk("t2_gt_count", gt_count, 1);
        chk("t2_lt_count", lt_count, 1);
        // signed pair: -128 is now the min, 0x7F beats it as max
        chk("t2_s_max", max_val, 8'h7F);
        chk("t2_s_min", min_val, 8'h80);
        tick();

        // backpressure
        out_ready = 1'b0;
        drive(1'b1, 8'h03, 8'h02, 1'b0);
        #1;
        chk("t3_ready_pre", in_ready, 1);
        tick();
        drive(1'b1, 8'h01, 8'h04, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_ready", in_ready, 0);
            chk("t3_stall_valid", out_valid, 1);
            chk("t3_stall_flags", {a_gt_b, a_lt_b, a_eq_b}, 3'b100);
            chk("t3_stall_gt_count", gt_count, 2);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t3_ready_release", in_ready, 1);
        tick();
        chk("t3_second", {out_valid, a_gt_b, a_lt_b, a_eq_b}, 4'b1010);
        drive(1'b1, 8'h06, 8'h06, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("t3_third", {out_valid, a_gt_b, a_lt_b, a_eq_b}, 4'b1001);
        chk("t3_counts", {gt_count, lt_count, eq_count}, {16'd2, 16'd2, 16'd1});

        // saturation on the CNT_W=2 instance
        clear = 1'b1;
        tick();
        clear = 1'b0;
        drive(1'b1, 8'h33, 8'h33, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("t4_eq_wide", eq_count, 5);
        chk("t4_eq_sat", s_eq_cnt, 2'd3);
        chk("t4_other_sat", {s_gt_cnt, s_lt_cnt}, 0);
        chk("t4_maxmin", {max_val, min_val}, 16'h3333);

        // clear and accept in the same cycle
        clear = 1'b1;
        drive(1'b1, 8'h10, 8'h10, 1'b0);
        tick();
        clear = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("t5_counts", {gt_count, lt_count, eq_count}, {16'd0, 16'd0, 16'd1});
        chk("t5_sat_eq", s_eq_cnt, 2'd1);
        chk("t5_maxmin", {max_val, min_val}, 16'h1010);
        chk("t5_stats_valid", stats_valid, 1);

        // further unsigned pair widens both extrema
        drive(1'b1, 8'h20, 8'h05, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("t5b_maxmin", {max_val, min_val}, 16'h2005);

        // async reset while a result is stalled
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h02, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("t6_pending", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_counts", {gt_count, lt_count, eq_count}, 0);
        chk("t6_rst_stats", {max_val, min_val, 7'd0, stats_valid}, 0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("t6_ready_after", in_ready, 1);
        tick();
        chk("t6_still_idle", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/comparator_stream.md
Name: comparator_stream

Overview:
- Parametrised, registered successor to the team's 8-bit magnitude comparator.
- Accepts operand pairs over a valid/ready handshake and compares them as signed or unsigned, selected per transaction.
- Presents one-hot GT/LT/EQ flags one cycle later, with backpressure.
- Keeps running statistics: saturating GT/LT/EQ counters and the running max/min of all operands seen. Sits between a data-producing datapath and a monitor/CSR block.

Parameters:
- WIDTH, 8, operand width in bits (≥2).
- CNT_W, 16, width of each statistics counter (≥2).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with the pair.
- clear  in  1  synchronous clear of statistics (counters, max/min, stats_valid).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- a_gt_b  out  1  A > B.
- a_lt_b  out  1  A < B.
- a_eq_b  out  1  A == B.
- gt_count  out  CNT_W  accepted pairs with A > B.
- lt_count  out  CNT_W  accepted pairs with A < B.
- eq_count  out  CNT_W  accepted pairs with A == B.
- max_val  out  WIDTH  largest operand seen since reset/clear.
- min_val  out  WIDTH  smallest operand seen since reset/clear.
- stats_valid  out  1  at least one pair accepted since reset/clear.

Behaviour:
- Reset (rst_n low, async):
  - out_valid, flags, counters, max_val, min_val and stats_valid all = 0.
  - in_ready = 1 once rst_n is high.
- Accept: a pair is accepted on a rising edge with in_valid && in_ready.
- Ready rule: in_ready = !out_valid || out_ready (combinational; single output register, no skid).
- Latency: result registered on the accepting edge, so out_valid rises 1 cycle after acceptance.
- Result hold:
  - Result holds stable while out_valid && !out_ready.
  - Result is consumed on out_valid && out_ready.
  - A new accept in the same cycle replaces it (full throughput, 1 pair/cycle).
  - With no new accept in that cycle, out_valid falls.
- Flags:
  - Exactly one of a_gt_b/a_lt_b/a_eq_b is high whenever out_valid = 1.
  - The last value is held when out_valid = 0.
- Compare mode: signed_mode = 1 interprets a and b as two's complement (e.g. WIDTH=8: 0x80 < 0x7F); 0 is unsigned (0x80 > 0x7F).
- Counters:
  - On accept, the counter matching the result increments.
  - Each counter saturates at 2^CNT_W−1 and never wraps.
  - Counters update on the accepting edge, independent of output backpressure.
- Max/min:
  - On accept, max_val/min_val update from {a, b, current value} using that pair's signed_mode.
  - On the first accept after reset/clear (stats_valid = 0), they load directly from max(a,b)/min(a,b), ignoring the stored values.
  - stats_valid is set on that edge.
  - Mixed-mode streams are legal; each update uses its own pair's mode.
- clear:
  - Zeroes counters, max/min and stats_valid.
  - Does not affect the handshake, out_valid or flags.
- clear && accept in the same cycle:
  - clear applies first, then the pair is counted as the first after clear.
  - Result: the matching counter = 1, others = 0; max/min loaded from the pair; stats_valid = 1.
- Reset mid-transaction: pending result discarded, out_valid = 0 immediately (async), all stats zeroed.
- in_valid without in_ready: operands are not sampled; the producer must hold them stable (AXI-style).

Decomposition:
- Package comparator_pkg:
  - cmp_result_t enum, 2-bit: CMP_LT = 0, CMP_EQ = 1, CMP_GT = 2.
  - Helper function for saturating increment.
- Sub-module cmp_core (parameter WIDTH):
  - Combinational: a, b, signed_mode in; cmp_result_t out.
  - Instantiated three times: pair compare, max update, min update.
- Top holds the handshake register, counters and max/min registers.

Test Plan:
- Reset then a=0x05, b=0x09, unsigned, out_ready=1 -> next cycle out_valid=1, a_lt_b=1, lt_count=1, max_val=0x09, min_val=0x05, stats_valid=1.
- a=0x80, b=0x7F, issued once unsigned then once signed -> results a_gt_b then a_lt_b; gt_count=1, lt_count=1.
- out_ready=0 with in_valid held high -> first result accepted, then in_ready=0; flags stable for 3 cycles; out_ready=1 -> next pair accepted the same cycle, back-to-back throughput.
- CNT_W=2, five pairs a=b=0x33 -> eq_count=3 (saturated), no wrap.
- Stats non-zero, clear and accept a=0x10, b=0x10 in the same cycle -> eq_count=1, gt_count=lt_count=0, max_val=min_val=0x10, stats_valid=1.
- rst_n pulsed low asynchronously while out_valid=1 and out_ready=0 -> out_valid and all stats 0 before the next edge; in_ready=1 after release.
